// File: rtl/ct_pkg.sv
// ct_pkg: shared helpers for the ct_* interconnect blocks.
// Provides ct_clog2 for parameter checks and the common pipeline depth limit.
package ct_pkg;

  // Deepest register chain any ct_* block supports.
  localparam int CT_MAX_PIPELINE = 8;

  // Ceiling log2; ct_clog2(1) = 0, ct_clog2(4) = 2, ct_clog2(5) = 3.
  function automatic int ct_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ct_pipe_mux_stage.sv
// ct_pipe_stage: one valid/payload register of the ct_pipe_mux chain.
// The stage loads when told to and drops its word when the next stage
// (or the consumer) takes it without a replacement arriving.
module ct_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next state: a load always wins; otherwise an advance empties the stage.
  always_comb begin
    valid_d = load_i | (valid_q & ~adv_i);
    data_d  = load_i ? data_i : data_q;
  end

  // Register with asynchronous clear of both valid and payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ct_pipe_mux.sv
// ct_pipe_mux: N:1 AND-OR word multiplexer followed by PIPELINE valid/ready
// register stages with bubble collapse. PIPELINE = 0 is a pure combinational
// passthrough. Optional feature macro CT_PIPE_MUX_SELERR_EN adds the sel_err
// output, an out-of-range-select flag carried alongside each word.
module ct_pipe_mux
  import ct_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIZE      = 4,
  parameter int SEL_WIDTH = 2,
  parameter int PIPELINE  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH*SIZE-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
`ifdef CT_PIPE_MUX_SELERR_EN
  output logic                  sel_err,
`endif
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

`ifdef CT_PIPE_MUX_SELERR_EN
  localparam int ERR_W = 1;
`else
  localparam int ERR_W = 0;
`endif
  localparam int PAY_W = WIDTH + ERR_W;

  if (SIZE < 1) begin : g_bad_size
    $error("ct_pipe_mux: SIZE must be at least 1");
  end
  if (ct_clog2(SIZE) > SEL_WIDTH) begin : g_bad_sel
    $error("ct_pipe_mux: SEL_WIDTH too narrow to address SIZE words");
  end
  if (PIPELINE < 0 || PIPELINE > CT_MAX_PIPELINE) begin : g_bad_pipe
    $error("ct_pipe_mux: PIPELINE out of range");
  end

  logic [WIDTH-1:0] sel_word;
  logic [PAY_W-1:0] pay_in;

  // AND-OR select: every word is masked by its own index match, so an
  // out-of-range select matches nothing and yields zero.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < SIZE; i++) begin
      sel_word |= in_data[i*WIDTH +: WIDTH] & {WIDTH{SEL_WIDTH'(i) == in_sel}};
    end
  end

`ifdef CT_PIPE_MUX_SELERR_EN
  logic sel_oor;
  assign sel_oor = ({1'b0, in_sel} >= (SEL_WIDTH+1)'(SIZE));
  assign pay_in  = {sel_oor, sel_word};
`else
  assign pay_in  = sel_word;
`endif

  if (PIPELINE == 0) begin : g_comb
    // No state at all: clock and reset are intentionally unused here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign out_data       = pay_in[WIDTH-1:0];
    assign out_valid      = in_valid;
    assign in_ready       = out_ready;
`ifdef CT_PIPE_MUX_SELERR_EN
    assign sel_err        = in_valid & pay_in[WIDTH];
`endif
  end else begin : g_pipe
    logic [PIPELINE-1:0] v;
    logic [PIPELINE:0]   chain_v;
    logic [PIPELINE:0]   take;
    logic [PAY_W-1:0]    chain_d [PIPELINE+1];

    // chain_v[k] / chain_d[k] is what feeds stage k; index 0 is the mux.
    assign chain_v    = {v, in_valid};
    assign chain_d[0] = pay_in;

    // Ready chain, evaluated from the output backwards: take[k] means stage k
    // loads this cycle, take[PIPELINE] means the consumer takes the last word.
    // An empty stage loads regardless of downstream, which collapses bubbles.
    always_comb begin
      take           = '0;
      take[PIPELINE] = out_ready;
      for (int k = PIPELINE-1; k >= 0; k--) begin
        take[k] = chain_v[k] & (~v[k] | take[k+1]);
      end
    end

    for (genvar k = 0; k < PIPELINE; k++) begin : g_stage
      ct_pipe_stage #(
        .WIDTH (PAY_W)
      ) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (take[k]),
        .adv_i   (take[k+1]),
        .data_i  (chain_d[k]),
        .valid_o (v[k]),
        .data_o  (chain_d[k+1])
      );
    end

    // Held low during reset so nothing is accepted into a clearing pipeline.
    assign in_ready  = reset_n & (~v[0] | take[1]);
    assign out_valid = v[PIPELINE-1];
    assign out_data  = chain_d[PIPELINE][WIDTH-1:0];
`ifdef CT_PIPE_MUX_SELERR_EN
    assign sel_err   = v[PIPELINE-1] & chain_d[PIPELINE][WIDTH];
`endif
  end

endmodule
